// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load-op bit positions, field widths,
// the per-entry sideband record, and width helpers for pointers and counters.
package mem_pkg;

  localparam int unsigned LD_W    = 0;
  localparam int unsigned LD_HU   = 1;
  localparam int unsigned LD_H    = 2;
  localparam int unsigned LD_BU   = 3;
  localparam int unsigned LD_B    = 4;
  localparam int unsigned LD_OP_W = 5;
  localparam int unsigned DATA_W  = 32;

  typedef struct packed {
    logic               mem_req;
    logic               res_from_mem;
    logic [LD_OP_W-1:0] ld_op;
    logic [DATA_W-1:0]  alu_result;
  } ms_fields_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Extra bit: back-to-back flushes can stack stale responses beyond DEPTH.
  function automatic int unsigned discard_w(input int unsigned depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/mem_ld_align.sv
// Load data alignment: picks the byte/half/word named by ld_op and addr and
// sign- or zero-extends it to 32 bits.
module mem_ld_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0]  rdata,
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         addr,
  output logic [DATA_W-1:0]  result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    result_c = rdata;
    if (ld_op[LD_B])       result_c = {{24{byte_sel[7]}}, byte_sel};
    else if (ld_op[LD_BU]) result_c = {24'b0, byte_sel};
    else if (ld_op[LD_H])  result_c = {{16{half_sel[15]}}, half_sel};
    else if (ld_op[LD_HU]) result_c = {16'b0, half_sel};
  end

endmodule

// File: rtl/mem_stage_mq.sv
// Multi-entry MEM stage: in-order queue of EXE entries awaiting data_ok, with
// stale-response discarding after flush. Define MEM_STAGE_PERF_EN to add
// the perf_wait_cnt head-stall counter output.
module mem_stage_mq
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned BUS_W = 192
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      es_to_ms_valid,
  output logic                      ms_allowin,
  input  logic [BUS_W-1:0]          es_to_ms_bus,
  input  logic                      es_mem_req,
  input  logic                      es_res_from_mem,
  input  logic [LD_OP_W-1:0]        es_ld_op,
  input  logic [DATA_W-1:0]         es_alu_result,
  input  logic                      data_sram_data_ok,
  input  logic [DATA_W-1:0]         data_sram_rdata,
  input  logic                      ws_allowin,
  output logic                      ms_to_ws_valid,
  output logic [BUS_W+DATA_W-1:0]   ms_to_ws_bus,
  input  logic                      flush,
  output logic                      ms_empty,
  output logic [cnt_w(DEPTH)-1:0]   ms_cnt
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]               perf_wait_cnt
`endif
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned DSC_W = discard_w(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DSC_W-1:0]  disc_q, disc_d;
  logic [DEPTH-1:0]  valid_q, valid_d, arrived_q, arrived_d;
  ms_fields_t        fld_q[DEPTH], fld_d[DEPTH];
  logic [BUS_W-1:0]  pay_q[DEPTH], pay_d[DEPTH];
  logic [DATA_W-1:0] rdata_q[DEPTH], rdata_d[DEPTH];

  logic              tgt_found;
  logic [PTR_W-1:0]  tgt_idx, scan_idx;
  logic [DSC_W-1:0]  pend_cnt;
  logic              ok_to_disc, ok_to_ent, ok_used, head_hit;
  logic              enq, deq;
  logic [DATA_W-1:0] head_rdata, ld_res;
  ms_fields_t        head_fld;

  // Oldest entry still waiting for its response, plus how many are waiting.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = head_q;
    scan_idx  = head_q;
    pend_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && fld_q[scan_idx].mem_req && !arrived_q[scan_idx]) begin
        pend_cnt = pend_cnt + DSC_W'(1);
        if (!tgt_found) begin
          tgt_found = 1'b1;
          tgt_idx   = scan_idx;
        end
      end
    end
  end

  assign ok_to_disc = data_sram_data_ok && (disc_q != '0);
  assign ok_to_ent  = data_sram_data_ok && (disc_q == '0) && tgt_found;
  assign ok_used    = ok_to_disc || ok_to_ent;
  assign head_hit   = ok_to_ent && (tgt_idx == head_q);
  assign head_fld   = fld_q[head_q];

  assign ms_allowin     = (cnt_q != CNT_W'(DEPTH)) && !flush;
  assign ms_to_ws_valid = valid_q[head_q] && !flush &&
                          (!head_fld.mem_req || arrived_q[head_q] || head_hit);
  assign enq            = es_to_ms_valid && ms_allowin;
  assign deq            = ms_to_ws_valid && ws_allowin;
  assign ms_empty       = (cnt_q == '0);
  assign ms_cnt         = cnt_q;

  // Same-cycle response for the head bypasses the capture register.
  assign head_rdata = head_hit ? data_sram_rdata : rdata_q[head_q];

  mem_ld_align u_ld_align (
    .rdata    (head_rdata),
    .ld_op    (head_fld.ld_op),
    .addr     (head_fld.alu_result[1:0]),
    .result_c (ld_res)
  );

  assign ms_to_ws_bus = {pay_q[head_q], head_fld.res_from_mem ? ld_res : head_fld.alu_result};

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    disc_d    = disc_q;
    valid_d   = valid_q;
    arrived_d = arrived_q;
    fld_d     = fld_q;
    pay_d     = pay_q;
    rdata_d   = rdata_q;
    if (flush) begin
      // Every response still owed to a dropped entry must be swallowed later.
      head_d    = '0;
      tail_d    = '0;
      cnt_d     = '0;
      valid_d   = '0;
      arrived_d = '0;
      disc_d    = disc_q + pend_cnt - DSC_W'(ok_used);
    end else begin
      if (ok_to_disc) disc_d = disc_q - DSC_W'(1);
      if (ok_to_ent) begin
        arrived_d[tgt_idx] = 1'b1;
        rdata_d[tgt_idx]   = data_sram_rdata;
      end
      if (deq) begin
        valid_d[head_q]   = 1'b0;
        arrived_d[head_q] = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end
      if (enq) begin
        valid_d[tail_q]   = 1'b1;
        arrived_d[tail_q] = 1'b0;
        fld_d[tail_q]     = '{mem_req: es_mem_req, res_from_mem: es_res_from_mem,
                              ld_op: es_ld_op, alu_result: es_alu_result};
        pay_d[tail_q]     = es_to_ms_bus;
        tail_d            = tail_q + PTR_W'(1);
      end
      if (enq && !deq)      cnt_d = cnt_q + CNT_W'(1);
      else if (!enq && deq) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      disc_q    <= '0;
      valid_q   <= '0;
      arrived_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      disc_q    <= disc_d;
      valid_q   <= valid_d;
      arrived_q <= arrived_d;
    end
  end

  always_ff @(posedge clk) begin
    fld_q   <= fld_d;
    pay_q   <= pay_d;
    rdata_q <= rdata_d;
  end

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (valid_q[head_q] && head_fld.mem_req && !arrived_q[head_q] &&
        !data_sram_data_ok && (perf_q != '1))
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_wait_cnt = perf_q;
`endif

endmodule

// File: tb/tb_mem_stage_mq.sv
// Self-checking bench for mem_stage_mq: extraction table, directed ordering /
// backpressure / flush / reset sequences, and random traffic against a queue model.
module tb_mem_stage_mq;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned BUS_W = 192;

  logic               clk = 1'b0;
  logic               reset;
  logic               es_to_ms_valid, ms_allowin, es_mem_req, es_res_from_mem;
  logic [BUS_W-1:0]   es_to_ms_bus;
  logic [4:0]         es_ld_op;
  logic [31:0]        es_alu_result, data_sram_rdata;
  logic               data_sram_data_ok, ws_allowin, ms_to_ws_valid, flush, ms_empty;
  logic [BUS_W+31:0]  ms_to_ws_bus;
  logic [1:0]         ms_cnt;

  mem_stage_mq #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_to_ms_bus(es_to_ms_bus), .es_mem_req(es_mem_req), .es_res_from_mem(es_res_from_mem),
    .es_ld_op(es_ld_op), .es_alu_result(es_alu_result), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .flush(flush), .ms_empty(ms_empty), .ms_cnt(ms_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [4:0]  op;
    logic        res;
    logic        mreq;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] exp;
  } xvec_t;

  typedef struct {
    logic [BUS_W-1:0] pay;
    logic             mreq;
    logic             res;
    logic [4:0]       op;
    logic [31:0]      alu;
    logic             arrived;
    logic [31:0]      rdata;
  } ment_t;

  localparam logic [4:0] OP_B = 5'b10000, OP_BU = 5'b01000, OP_H = 5'b00100,
                         OP_HU = 5'b00010, OP_W = 5'b00001;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid = 0; es_mem_req = 0; es_res_from_mem = 0; es_ld_op = '0;
    es_alu_result = '0; es_to_ms_bus = '0; data_sram_data_ok = 0; data_sram_rdata = '0;
    flush = 0;
  endtask

  task automatic do_reset();
    idle();
    ws_allowin = 1;
    reset = 1;
    #2;
    reset = 0;
    tick();
  endtask

  task automatic offer(input logic [BUS_W-1:0] pay, input logic mreq, input logic res,
                       input logic [4:0] op, input logic [31:0] alu);
    es_to_ms_valid = 1; es_to_ms_bus = pay; es_mem_req = mreq;
    es_res_from_mem = res; es_ld_op = op; es_alu_result = alu;
  endtask

  task automatic dok(input logic ok, input logic [31:0] rd);
    data_sram_data_ok = ok;
    data_sram_rdata   = rd;
  endtask

  function automatic logic [BUS_W-1:0] rnd_pay();
    logic [BUS_W-1:0] p;
    for (int i = 0; i < 6; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Reference load extraction from shift/mask arithmetic.
  function automatic logic [31:0] ref_ld(input logic [4:0] op, input logic [31:0] rd,
                                         input logic [1:0] a);
    logic [31:0] b, h;
    b = (rd >> (32'(a) * 8)) & 32'hFF;
    h = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
    if (op[4]) return b[7] ? (b | 32'hFFFF_FF00) : b;
    if (op[3]) return b;
    if (op[2]) return h[15] ? (h | 32'hFFFF_0000) : h;
    if (op[1]) return h;
    return rd;
  endfunction

  initial begin
    xvec_t            xv[10];
    ment_t            mq[$];
    ment_t            ne, hd;
    int               disc, waiting, tgt;
    logic             fl, v, ok, wsa, ev, ea;
    logic [BUS_W-1:0] p0, p1, p2;
    logic [31:0]      er;

    xv[0] = '{OP_B,  1, 1, 32'h1000_0003, 32'h80FF_0000, 32'hFFFF_FF80};
    xv[1] = '{OP_BU, 1, 1, 32'h1000_0003, 32'h80FF_0000, 32'h0000_0080};
    xv[2] = '{OP_B,  1, 1, 32'h1000_0002, 32'h80FF_0000, 32'hFFFF_FFFF};
    xv[3] = '{OP_BU, 1, 1, 32'h1000_0000, 32'h1234_56F0, 32'h0000_00F0};
    xv[4] = '{OP_H,  1, 1, 32'h1000_0002, 32'h8001_7FFF, 32'hFFFF_8001};
    xv[5] = '{OP_HU, 1, 1, 32'h1000_0002, 32'h8001_7FFF, 32'h0000_8001};
    xv[6] = '{OP_H,  1, 1, 32'h1000_0000, 32'h8001_7FFF, 32'h0000_7FFF};
    xv[7] = '{OP_W,  1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    xv[8] = '{5'b0,  1, 1, 32'h1000_0001, 32'hCAFE_F00D, 32'hCAFE_F00D};
    xv[9] = '{5'b0,  0, 0, 32'h1111_2222, 32'h0,         32'h1111_2222};

    idle();
    ws_allowin = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_empty",   256'(ms_empty), 256'(1));
    chk("rst_valid",   256'(ms_to_ws_valid), 256'(0));
    chk("rst_allowin", 256'(ms_allowin), 256'(1));
    chk("rst_cnt",     256'(ms_cnt), 256'(0));
    tick();

    // Extraction table: enqueue, then response on the next cycle retires at once.
    for (int i = 0; i < 10; i++) begin
      p0 = rnd_pay();
      offer(p0, xv[i].mreq, xv[i].res, xv[i].op, xv[i].alu);
      #1;
      chk("x_no_bypass", 256'(ms_to_ws_valid), 256'(0));
      tick();
      idle();
      dok(xv[i].mreq, xv[i].rd);
      #1;
      chk("x_valid", 256'(ms_to_ws_valid), 256'(1));
      chk("x_result", 256'(ms_to_ws_bus), 256'({p0, xv[i].exp}));
      tick();
      idle();
    end

    // Back-to-back loads, responses 3 and 5 cycles after the first enqueue.
    do_reset();
    p1 = rnd_pay();
    p2 = rnd_pay();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) offer(p1, 1, 1, OP_W, 32'h2000_0000);
      if (c == 1) offer(p2, 1, 1, OP_W, 32'h2000_0004);
      if (c == 3) dok(1, 32'h1111_AAAA);
      if (c == 5) dok(1, 32'h2222_BBBB);
      #1;
      chk("b2b_valid", 256'(ms_to_ws_valid), 256'(c == 3 || c == 5));
      if (c == 3) chk("b2b_first",  256'(ms_to_ws_bus), 256'({p1, 32'h1111_AAAA}));
      if (c == 5) chk("b2b_second", 256'(ms_to_ws_bus), 256'({p2, 32'h2222_BBBB}));
      tick();
    end
    chk("b2b_drained", 256'(ms_empty), 256'(1));

    // Backpressure with WB stalled.
    do_reset();
    p0 = rnd_pay(); p1 = rnd_pay(); p2 = rnd_pay();
    ws_allowin = 0;
    offer(p0, 0, 0, 5'b0, 32'h0A); #1;
    chk("bp_allow0", 256'(ms_allowin), 256'(1));
    tick();
    offer(p1, 0, 0, 5'b0, 32'h0B); #1;
    chk("bp_allow1", 256'(ms_allowin), 256'(1));
    tick();
    offer(p2, 0, 0, 5'b0, 32'h0C); #1;
    chk("bp_full", 256'(ms_allowin), 256'(0));
    chk("bp_cnt2", 256'(ms_cnt), 256'(2));
    tick();
    ws_allowin = 1; #1;
    chk("bp_take_allow", 256'(ms_allowin), 256'(0));
    chk("bp_head0", 256'(ms_to_ws_bus), 256'({p0, 32'h0A}));
    tick();
    ws_allowin = 0; #1;
    chk("bp_reopen", 256'(ms_allowin), 256'(1));
    chk("bp_cnt1", 256'(ms_cnt), 256'(1));
    tick();
    idle(); ws_allowin = 1; #1;
    chk("bp_cnt_again", 256'(ms_cnt), 256'(2));
    chk("bp_head1", 256'(ms_to_ws_bus), 256'({p1, 32'h0B}));
    tick();
    chk("bp_head2", 256'(ms_to_ws_bus), 256'({p2, 32'h0C}));
    tick();
    chk("bp_empty", 256'(ms_empty), 256'(1));

    // Flush with two loads outstanding; the next two responses are stale.
    do_reset();
    p0 = rnd_pay();
    offer(rnd_pay(), 1, 1, OP_W, 32'h3000_0000); tick();
    offer(rnd_pay(), 1, 1, OP_W, 32'h3000_0004); tick();
    idle(); flush = 1; #1;
    chk("fl_valid", 256'(ms_to_ws_valid), 256'(0));
    chk("fl_allowin", 256'(ms_allowin), 256'(0));
    tick();
    idle(); offer(p0, 1, 1, OP_W, 32'h3000_0008); #1;
    chk("fl_cleared", 256'(ms_cnt), 256'(0));
    tick();
    idle(); dok(1, 32'hBAD0_0001); #1;
    chk("fl_stale1", 256'(ms_to_ws_valid), 256'(0));
    tick();
    dok(1, 32'hBAD0_0002); #1;
    chk("fl_stale2", 256'(ms_to_ws_valid), 256'(0));
    tick();
    dok(1, 32'h1234_5678); #1;
    chk("fl_new_valid", 256'(ms_to_ws_valid), 256'(1));
    chk("fl_new_data", 256'(ms_to_ws_bus), 256'({p0, 32'h1234_5678}));
    tick();
    idle(); #1;
    chk("fl_empty", 256'(ms_empty), 256'(1));

    // Flush on the same cycle a response lands: only one response left to drop.
    do_reset();
    p0 = rnd_pay();
    offer(rnd_pay(), 1, 1, OP_W, 32'h4000_0000); tick();
    offer(rnd_pay(), 1, 1, OP_W, 32'h4000_0004); tick();
    idle(); flush = 1; dok(1, 32'hBAD1_0001); #1;
    chk("flok_valid", 256'(ms_to_ws_valid), 256'(0));
    tick();
    idle(); offer(p0, 1, 1, OP_W, 32'h4000_0008); tick();
    idle(); dok(1, 32'hBAD1_0002); #1;
    chk("flok_stale", 256'(ms_to_ws_valid), 256'(0));
    tick();
    dok(1, 32'hA5A5_0003); #1;
    chk("flok_valid_new", 256'(ms_to_ws_valid), 256'(1));
    chk("flok_data", 256'(ms_to_ws_bus), 256'({p0, 32'hA5A5_0003}));
    tick();
    idle();

    // Asynchronous reset with entries pending.
    do_reset();
    ws_allowin = 0;
    offer(rnd_pay(), 0, 0, 5'b0, 32'h5); tick();
    offer(rnd_pay(), 0, 0, 5'b0, 32'h6); tick();
    idle(); #1;
    chk("ar_pre_cnt", 256'(ms_cnt), 256'(2));
    reset = 1; #1;
    chk("ar_cnt",   256'(ms_cnt), 256'(0));
    chk("ar_valid", 256'(ms_to_ws_valid), 256'(0));
    chk("ar_empty", 256'(ms_empty), 256'(1));
    #1 reset = 0;
    tick();

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    disc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      waiting = 0;
      tgt = -1;
      foreach (mq[i]) if (mq[i].mreq && !mq[i].arrived) begin
        waiting++;
        if (tgt < 0) tgt = i;
      end
      fl  = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 2) != 0);
      wsa = ($urandom_range(0, 3) != 0);
      ok  = (disc + waiting > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      ne.pay = rnd_pay();
      ne.res = 1'($urandom_range(0, 1));
      ne.mreq = ne.res ? 1'b1 : ($urandom_range(0, 3) == 0);
      begin
        int k;
        k = $urandom_range(0, 5);
        ne.op = (k == 5) ? 5'd0 : 5'(5'd1 << k);
      end
      ne.alu = $urandom;
      ne.arrived = 0;
      ne.rdata = $urandom;
      er = $urandom;
      flush = fl;
      ws_allowin = wsa;
      dok(ok, er);
      if (v) offer(ne.pay, ne.mreq, ne.res, ne.op, ne.alu);
      #1;
      if (!ok || disc > 0) tgt = -1;
      ea = (mq.size() != DEPTH) && !fl;
      ev = 0;
      if (mq.size() > 0) begin
        hd = mq[0];
        if (tgt == 0) begin hd.arrived = 1; hd.rdata = er; end
        ev = !fl && (!hd.mreq || hd.arrived);
      end
      chk("rnd_allowin", 256'(ms_allowin), 256'(ea));
      chk("rnd_valid", 256'(ms_to_ws_valid), 256'(ev));
      chk("rnd_cnt", 256'(ms_cnt), 256'(mq.size()));
      chk("rnd_empty", 256'(ms_empty), 256'(mq.size() == 0));
      if (ev)
        chk("rnd_bus", 256'(ms_to_ws_bus),
            256'({hd.pay, hd.res ? ref_ld(hd.op, hd.rdata, hd.alu[1:0]) : hd.alu}));
      if (fl) begin
        disc = disc + waiting - ((ok && (disc > 0 || tgt >= 0)) ? 1 : 0);
        mq.delete();
      end else begin
        if (ok && disc > 0) disc--;
        if (tgt >= 0) begin mq[tgt].arrived = 1; mq[tgt].rdata = er; end
        if (ev && wsa) void'(mq.pop_front());
        if (v && ea) mq.push_back(ne);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
